// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver, LSB first, mid-bit sampling, with a
//            one-entry valid/ready output buffer plus framing-error and
//            overrun pulses.
// Ports    : clk        - system clock
//            rst_n      - asynchronous reset, active low
//            rx         - serial line (idle high, asynchronous to clk)
//            data[7:0]  - received byte, meaningful while valid=1
//            valid      - data holds an unconsumed byte
//            ready      - consumer takes data on a valid&ready cycle
//            frame_err  - one-cycle pulse: stop bit sampled low
//            overrun    - one-cycle pulse: good byte dropped, buffer full
//            busy       - receiver is inside a frame (state != IDLE)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLK_DIV = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int                 c_CNT_W = $clog2(CLK_DIV) + 1;
  localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(CLK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Synchroniser and falling-edge detector
  // --------------------------------------------------------------------------
  logic       rx_meta_q;
  logic       rx_s_q;
  logic       rx_prev_q;
  // live_q[n] marks that stage n of the chain holds a real line sample rather
  // than its reset value. Without it a line already low at reset release would
  // look like a 1->0 transition of rx_s and start a bogus frame.
  logic [2:0] live_q;
  logic       w_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      live_q    <= 3'b000;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      live_q    <= {live_q[1:0], 1'b1};
    end
  end

  assign w_fall = live_q[2] & rx_prev_q & ~rx_s_q;

  // --------------------------------------------------------------------------
  // Receive state machine and output buffer
  // --------------------------------------------------------------------------
  state_t             state_q;
  logic [c_CNT_W-1:0] cnt_q;
  logic [2:0]         bit_idx_q;
  logic [7:0]         shift_q;
  logic               w_tick;

  assign w_tick = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Consumption; a byte completing in this same cycle overrides below.
      if (valid && ready) begin
        valid <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (w_fall) begin
            state_q <= S_START;
            cnt_q   <= c_HALF;
            busy    <= 1'b1;
          end
        end

        S_START: begin
          if (w_tick) begin
            if (!rx_s_q) begin
              state_q   <= S_DATA;
              bit_idx_q <= 3'd0;
              cnt_q     <= c_FULL;
            end else begin
              // Start bit did not survive to mid-bit: glitch, drop silently.
              state_q <= S_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - c_ONE;
          end
        end

        S_DATA: begin
          if (w_tick) begin
            shift_q[bit_idx_q] <= rx_s_q;
            cnt_q              <= c_FULL;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - c_ONE;
          end
        end

        S_STOP: begin
          if (w_tick) begin
            // Leave at mid-stop-bit so a start bit right after it is caught.
            state_q <= S_IDLE;
            busy    <= 1'b0;
            if (rx_s_q) begin
              if (!valid || ready) begin
                data  <= shift_q;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - c_ONE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx with CLK_DIV=16.
//            Stimulus is driven on the falling clock edge; a monitor samples
//            DUT outputs 1 time unit after each falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int c_DIV   = 16;
  localparam int c_FRAME = 10 * c_DIV;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(.CLK_DIV(c_DIV)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: event counters observed by the main sequence as deltas.
  int         valid_cyc = 0;
  int         fe_cyc    = 0;
  int         ov_cyc    = 0;
  int         busy_cyc  = 0;
  logic       valid_d   = 1'b0;
  int         rise_q[$];
  logic [7:0] acc_q[$];

  always @(negedge clk) begin
    #1;
    if (valid) valid_cyc++;
    if (valid && !valid_d) rise_q.push_back(cyc);
    valid_d = valid;
    if (valid && ready) acc_q.push_back(data);
    if (frame_err) fe_cyc++;
    if (overrun) ov_cyc++;
    if (busy) busy_cyc++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one full frame starting at a falling edge. ready_at pulses ready
  // high for one cycle at that bit-time offset; rst_at pulses rst_n low for
  // two cycles at that offset and checks the async-cleared outputs.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int ready_at, input int rst_at);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < c_FRAME; i++) begin
      rx = fr[i / c_DIV];
      if (ready_at >= 0 && i == ready_at) ready = 1'b1;
      else if (ready_at >= 0 && i == ready_at + 1) ready = 1'b0;
      if (rst_at >= 0 && i == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("midrst_data", {24'd0, data}, 32'h00);
        check("midrst_valid", {31'd0, valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ferr", {31'd0, frame_err}, 32'd0);
      end
      if (rst_at >= 0 && i == rst_at + 2) rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  int s_acc, s_valid, s_fe, s_ov, s_busy, s_rise, t0, lat;

  task automatic snap();
    s_acc   = acc_q.size();
    s_valid = valid_cyc;
    s_fe    = fe_cyc;
    s_ov    = ov_cyc;
    s_busy  = busy_cyc;
    s_rise  = rise_q.size();
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_data", {24'd0, data}, 32'h00);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);

    // Back-to-back 0x55, 0xA3 with ready held high; latency of first byte.
    ready = 1'b1;
    snap();
    t0 = cyc;
    send_frame(8'h55, 1'b1, -1, -1);
    send_frame(8'hA3, 1'b1, -1, -1);
    idle(40);
    check("b2b_count", acc_q.size() - s_acc, 2);
    if (acc_q.size() >= s_acc + 2) begin
      check("b2b_byte0", {24'd0, acc_q[s_acc]}, 32'h55);
      check("b2b_byte1", {24'd0, acc_q[s_acc+1]}, 32'hA3);
    end
    check("b2b_valid_cycles", valid_cyc - s_valid, 2);
    check("b2b_ferr", fe_cyc - s_fe, 0);
    check("b2b_ovr", ov_cyc - s_ov, 0);
    lat = (rise_q.size() > s_rise) ? rise_q[s_rise] - t0 : -1;
    check("b2b_latency_155pm1", {31'd0, (lat >= 154 && lat <= 156)}, 1);

    // Short start glitch: 4 cycles low.
    snap();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    check("glitch_busy_8pm1", {31'd0, (busy_cyc - s_busy >= 7 && busy_cyc - s_busy <= 9)}, 1);
    check("glitch_valid", valid_cyc - s_valid, 0);
    check("glitch_ferr", fe_cyc - s_fe, 0);

    // Framing error on 0x3C, then a good 0x7E.
    snap();
    send_frame(8'h3C, 1'b0, -1, -1);
    idle(40);
    check("ferr_pulse_cycles", fe_cyc - s_fe, 1);
    check("ferr_valid", valid_cyc - s_valid, 0);
    send_frame(8'h7E, 1'b1, -1, -1);
    idle(40);
    check("after_ferr_count", acc_q.size() - s_acc, 1);
    if (acc_q.size() > s_acc) check("after_ferr_byte", {24'd0, acc_q[s_acc]}, 32'h7E);
    check("after_ferr_ferr", fe_cyc - s_fe, 1);

    // Overrun: ready low, 0x11 then 0x22.
    ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, -1, -1);
    idle(40);
    check("ovr_valid", {31'd0, valid}, 1);
    check("ovr_data", {24'd0, data}, 32'h11);
    check("ovr_pulse_cycles", ov_cyc - s_ov, 1);
    check("ovr_ferr", fe_cyc - s_fe, 0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("consume_valid", {31'd0, valid}, 0);
    check("consume_data_held", {24'd0, data}, 32'h11);

    // Consume on the exact stop-sample cycle of the next byte.
    idle(10);
    send_frame(8'h11, 1'b1, -1, -1);
    idle(20);
    snap();
    send_frame(8'h22, 1'b1, 9 * c_DIV + 10, -1);
    idle(20);
    check("simul_ovr", ov_cyc - s_ov, 0);
    check("simul_valid", {31'd0, valid}, 1);
    check("simul_data", {24'd0, data}, 32'h22);
    check("simul_consumed_old", acc_q.size() - s_acc, 1);

    // Reset during data bit 4 of 0x0F (line low at release), then 0x5A.
    send_frame(8'h0F, 1'b1, -1, 5 * c_DIV + 6);
    snap();
    idle(200);
    check("postrst_valid", {31'd0, valid}, 0);
    check("postrst_valid_cycles", valid_cyc - s_valid, 0);
    check("postrst_ferr", fe_cyc - s_fe, 0);
    ready = 1'b1;
    send_frame(8'h5A, 1'b1, -1, -1);
    idle(40);
    check("postrst_count", acc_q.size() - s_acc, 1);
    if (acc_q.size() > s_acc) check("postrst_byte", {24'd0, acc_q[s_acc]}, 32'h5A);
    check("postrst_ferr2", fe_cyc - s_fe, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
